// File: rtl/fetch_controller_pkg.sv
// Shared fetch types and constants: FSM states, instruction size, alignment check.
// Pure declarations; no latency or backpressure of its own.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALTED,
    FAULT
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK  = 2'b11;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch bus: imem req/gnt + rvalid on one side, held-instruction valid/ready to decode on the other.
// master = fetch controller; slave = memory and decode environment.
interface fetch_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [31:0]           imem_rdata;
  logic                  instr_valid;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_controller_wait_timer.sv
// Counts cycles spent waiting for read data; expired flags the final allowed cycle.
// Single-cycle clear; counting stalls once expired.
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: one outstanding imem request, holds each instruction until decode takes it.
// REQ->WAIT->HOLD gives instr_valid 2 cycles after the request; decode stall holds HOLD with no new request.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_enable,
  output logic                  jump_en,
  output logic [ADDR_WIDTH-1:0] jump_to,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  halt,
  output logic                  fetch_fault,
  fetch_controller_if.master    bus
);

  fetch_state_t          state_q, state_d;
  logic                  discard_q, discard_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_vld_q, addr_vld_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  redir_ok, redir_bad;
  logic                  timer_expired;
  logic [ADDR_WIDTH-1:0] req_addr;

  assign redir_ok  = redirect_en &&  is_aligned(redirect_target[1:0]);
  assign redir_bad = redirect_en && !is_aligned(redirect_target[1:0]);

  // The PC register advances on the same edge that enters REQ, so the first REQ
  // cycle presents pc directly and captures it; later cycles replay the capture.
  assign req_addr = (state_q == REQ && !addr_vld_q) ? pc : addr_q;

  assign bus.imem_addr = req_addr;
  assign bus.instr     = instr_q;
  assign bus.instr_pc  = instr_pc_q;
  assign fetch_fault   = (state_q == FAULT);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_q != WAIT),
    .count_en ((state_q == WAIT) && !bus.imem_rvalid),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d         = state_q;
    discard_d       = discard_q;
    addr_d          = addr_q;
    addr_vld_d      = 1'b0;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    pc_enable       = 1'b0;
    jump_en         = 1'b0;
    jump_to         = '0;
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = halt ? HALTED : REQ;
      end
      REQ: begin
        bus.imem_req = 1'b1;
        addr_d       = req_addr;
        addr_vld_d   = !bus.imem_gnt;
        if (redir_ok) discard_d = 1'b1;
        if (bus.imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (redir_ok) discard_d = 1'b1;
        if (bus.imem_rvalid) begin
          if (discard_q || redir_ok) begin
            discard_d = 1'b0;
            state_d   = halt ? HALTED : REQ;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = addr_q;
            state_d    = HOLD;
          end
        end else if (timer_expired) begin
          state_d = FAULT;
        end
      end
      HOLD: begin
        bus.instr_valid = !redirect_en;
        if (redir_ok) begin
          state_d = REQ;
        end else if (bus.instr_ready) begin
          pc_enable = 1'b1;
          state_d   = halt ? HALTED : REQ;
        end
      end
      HALTED: begin
        if (!halt) state_d = REQ;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect takes priority over any sequential increment chosen above.
    if (state_q != FAULT) begin
      if (redir_ok) begin
        pc_enable = 1'b1;
        jump_en   = 1'b1;
        jump_to   = redirect_target;
      end else if (redir_bad) begin
        pc_enable = 1'b0;
        jump_en   = 1'b0;
        state_d   = FAULT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      discard_q  <= 1'b0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a simple program-counter model.
// Walks nominal fetch, stall, redirects, halt, timeout fault and misaligned fault.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int AW = 32;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] pc_r;
  logic          pc_enable;
  logic          jump_en;
  logic [AW-1:0] jump_to;
  logic          redirect_en;
  logic [AW-1:0] redirect_target;
  logic          halt;
  logic          fetch_fault;

  int n_checks;
  int n_fail;

  fetch_controller_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_controller #(
    .ADDR_WIDTH (AW),
    .TIMEOUT    (16)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pc              (pc_r),
    .pc_enable       (pc_enable),
    .jump_en         (jump_en),
    .jump_to         (jump_to),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .halt            (halt),
    .fetch_fault     (fetch_fault),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter owned by the environment.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r <= '0;
    end else if (pc_enable) begin
      pc_r <= jump_en ? jump_to : pc_r + AW'(INSTR_BYTES);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n         = 1'b0;
    redirect_en     = 1'b0;
    redirect_target = '0;
    halt            = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req",    bus.imem_req,    1'b0);
    chk("rst_addr",   bus.imem_addr,   32'h0);
    chk("rst_valid",  bus.instr_valid, 1'b0);
    chk("rst_instr",  bus.instr,       32'h0);
    chk("rst_fault",  fetch_fault,     1'b0);
    chk("rst_pcen",   pc_enable,       1'b0);
    chk("rst_jumpto", jump_to,         32'h0);

    // Nominal fetch at pc=0: IDLE, REQ, WAIT, HOLD
    reset_n = 1'b1;
    #1;
    chk("idle_req", bus.imem_req, 1'b0);
    tick();
    chk("req0_vld",  bus.imem_req,  1'b1);
    chk("req0_addr", bus.imem_addr, 32'h0);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    #1;
    chk("wait0_req", bus.imem_req, 1'b0);
    chk("wait0_vld", bus.instr_valid, 1'b0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00500093;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    #1;
    chk("hold0_vld",  bus.instr_valid, 1'b1);
    chk("hold0_data", bus.instr,       32'h00500093);
    chk("hold0_pc",   bus.instr_pc,    32'h0);

    // Decode backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", bus.instr,       32'h00500093);
      chk("stall_pc",   bus.instr_pc,    32'h0);
      chk("stall_pcen", pc_enable,       1'b0);
      chk("stall_req",  bus.imem_req,    1'b0);
      chk("stall_vld",  bus.instr_valid, 1'b1);
    end
    bus.instr_ready = 1'b1;
    #1;
    chk("hand_pcen", pc_enable, 1'b1);
    chk("hand_jmp",  jump_en,   1'b0);
    tick();
    bus.instr_ready = 1'b0;
    #1;
    chk("req1_vld",  bus.imem_req,    1'b1);
    chk("req1_addr", bus.imem_addr,   32'h4);
    chk("req1_ivld", bus.instr_valid, 1'b0);

    // Redirect to 0x100 while waiting; late data must be dropped
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    redirect_en     = 1'b1;
    redirect_target = 32'h100;
    #1;
    chk("rdw_pcen", pc_enable, 1'b1);
    chk("rdw_jmp",  jump_en,   1'b1);
    chk("rdw_to",   jump_to,   32'h100);
    tick();
    redirect_en     = 1'b0;
    redirect_target = 32'h0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEADBEEF;
    #1;
    chk("rdw_drop_vld", bus.instr_valid, 1'b0);
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    #1;
    chk("rdw_next_vld",  bus.instr_valid, 1'b0);
    chk("rdw_next_req",  bus.imem_req,    1'b1);
    chk("rdw_next_addr", bus.imem_addr,   32'h100);

    // Redirect to 0x200 in first REQ cycle with gnt delayed 3 cycles
    redirect_en     = 1'b1;
    redirect_target = 32'h200;
    #1;
    chk("rdr_addr0", bus.imem_addr, 32'h100);
    chk("rdr_to",    jump_to,       32'h200);
    tick();
    redirect_en     = 1'b0;
    redirect_target = 32'h0;
    #1;
    chk("rdr_addr1", bus.imem_addr, 32'h100);
    chk("rdr_req1",  bus.imem_req,  1'b1);
    tick();
    chk("rdr_addr2", bus.imem_addr, 32'h100);
    tick();
    bus.imem_gnt = 1'b1;
    #1;
    chk("rdr_addr3", bus.imem_addr, 32'h100);
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h11111111;
    #1;
    chk("rdr_drop_vld", bus.instr_valid, 1'b0);
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    #1;
    chk("rdr_next_vld",  bus.instr_valid, 1'b0);
    chk("rdr_next_addr", bus.imem_addr,   32'h200);

    // Halt raised mid-transaction: finish, hand off, then park
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    halt = 1'b1;
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h22222222;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    #1;
    chk("halt_vld",  bus.instr_valid, 1'b1);
    chk("halt_data", bus.instr,       32'h22222222);
    chk("halt_pc",   bus.instr_pc,    32'h200);
    bus.instr_ready = 1'b1;
    #1;
    chk("halt_pcen", pc_enable, 1'b1);
    tick();
    bus.instr_ready = 1'b0;
    #1;
    chk("halted_req0", bus.imem_req,    1'b0);
    chk("halted_vld",  bus.instr_valid, 1'b0);
    tick();
    chk("halted_req1", bus.imem_req, 1'b0);
    halt = 1'b0;
    tick();
    chk("resume_req",  bus.imem_req,  1'b1);
    chk("resume_addr", bus.imem_addr, 32'h204);

    // Timeout: 16 WAIT cycles without rvalid
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    #1;
    chk("to_wait1", fetch_fault, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      tick();
      chk("to_waitn", fetch_fault, 1'b0);
    end
    tick();
    chk("to_fault", fetch_fault,  1'b1);
    chk("to_req",   bus.imem_req, 1'b0);
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fault_sticky", fetch_fault,     1'b1);
      chk("fault_noreq",  bus.imem_req,    1'b0);
      chk("fault_novld",  bus.instr_valid, 1'b0);
    end
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;

    // Reset clears the fault and restarts from IDLE
    reset_n = 1'b0;
    #1;
    chk("rst2_fault", fetch_fault,  1'b0);
    chk("rst2_req",   bus.imem_req, 1'b0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst2_idle", bus.imem_req, 1'b0);
    tick();
    chk("rst2_req_vld",  bus.imem_req,  1'b1);
    chk("rst2_req_addr", bus.imem_addr, 32'h0);

    // Misaligned redirect to 0x102 enters FAULT without a PC update
    redirect_en     = 1'b1;
    redirect_target = 32'h102;
    #1;
    chk("mis_pcen", pc_enable, 1'b0);
    chk("mis_jmp",  jump_en,   1'b0);
    tick();
    redirect_en     = 1'b0;
    redirect_target = 32'h0;
    #1;
    chk("mis_fault", fetch_fault,  1'b1);
    chk("mis_req",   bus.imem_req, 1'b0);
    chk("mis_pc",    pc_r,         32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
